term_switch_matrix_cfg: RTL and testbench



---
 rtl/term_sm_pkg.sv | 23 ++
 rtl/term_sm_cfg_chain.sv | 108 ++++++++++
 rtl/term_switch_matrix_cfg.sv | 75 +++++++
 tb/tb_term_switch_matrix_cfg.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/term_sm_pkg.sv
// Shared types and helpers for the runtime-configurable terminal-tile switch matrix.
package term_sm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

  function automatic int calc_sel_w(input int num_in);
    return (num_in > 1) ? $clog2(num_in) : 1;
  endfunction

  function automatic int calc_cfg_bits(input int num_in, input int num_out);
    return num_out * calc_sel_w(num_in);
  endfunction

  // Legacy reversed wiring: output i listens to input NUM_IN-1-(i mod NUM_IN).
  function automatic int default_sel(input int out_idx, input int num_in);
    return num_in - 1 - (out_idx % num_in);
  endfunction

endpackage

// File: rtl/term_sm_cfg_chain.sv
// Serial config chain: shadow shift register, bit counter, load FSM and atomic
// commit into the active select vector that steers the output muxes.
module term_sm_cfg_chain
  import term_sm_pkg::*;
#(
  parameter int NUM_IN   = 80,
  parameter int NUM_OUT  = 72,
  parameter int SEL_W    = calc_sel_w(NUM_IN),
  parameter int CFG_BITS = calc_cfg_bits(NUM_IN, NUM_OUT)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_cfg_en,
  input  logic                i_cfg_din,
  input  logic                i_cfg_commit,
  output logic                o_cfg_dout,
  output logic                o_cfg_valid,
  output logic                o_cfg_err,
  output logic [CFG_BITS-1:0] o_active_sel
);

  localparam int CNT_W = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

  function automatic logic [CFG_BITS-1:0] build_default_map();
    logic [CFG_BITS-1:0] v;
    v = {CFG_BITS{1'b0}};
    for (int k = 0; k < NUM_OUT; k++) begin
      v[k*SEL_W +: SEL_W] = SEL_W'(default_sel(k, NUM_IN));
    end
    return v;
  endfunction

  localparam logic [CFG_BITS-1:0] DEFAULT_MAP = build_default_map();

  cfg_state_e          r_state;
  cfg_state_e          w_next_state;
  logic [CFG_BITS-1:0] r_shadow;
  logic [CFG_BITS-1:0] r_active;
  logic [CNT_W-1:0]    r_count;
  logic                r_dout;
  logic                r_valid;
  logic                r_err;
  logic                w_full;
  logic                w_shift;

  // Commit wins over a simultaneous shift; the shift bit is simply dropped.
  assign w_full  = (r_count == CNT_FULL);
  assign w_shift = i_cfg_en & ~i_cfg_commit;

  // Load-sequence next state.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_cfg_commit) w_next_state = COMMIT;
        else if (i_cfg_en) w_next_state = SHIFT;
        else w_next_state = IDLE;
      end
      SHIFT: begin
        if (i_cfg_commit) w_next_state = COMMIT;
        else w_next_state = SHIFT;
      end
      COMMIT: begin
        if (i_cfg_commit) w_next_state = COMMIT;
        else w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Shadow shift, saturating count, and commit/error evaluation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow <= {CFG_BITS{1'b0}};
      r_active <= DEFAULT_MAP;
      r_count  <= {CNT_W{1'b0}};
      r_dout   <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else if (i_cfg_commit) begin
      if (w_full) begin
        r_active <= r_shadow;
        r_count  <= {CNT_W{1'b0}};
        r_valid  <= 1'b1;
        r_err    <= 1'b0;
      end else begin
        r_err    <= 1'b1;
      end
    end else if (w_shift) begin
      r_shadow <= {r_shadow[CFG_BITS-2:0], i_cfg_din};
      r_dout   <= r_shadow[CFG_BITS-1];
      if (!w_full) r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_cfg_dout   = r_dout;
  assign o_cfg_valid  = r_valid;
  assign o_cfg_err    = r_err;
  assign o_active_sel = r_active;

endmodule

// File: rtl/term_switch_matrix_cfg.sv
// Terminal-tile switch matrix with per-output runtime-selectable input muxes.
// Optional macro OUTPUT_REG_EN registers sig_out (one cycle of latency).
module term_switch_matrix_cfg
  import term_sm_pkg::*;
#(
  parameter int NUM_IN  = 80,
  parameter int NUM_OUT = 72
) (
  input  logic               UserCLK,
  input  logic               resetn,
  input  logic [NUM_IN-1:0]  sig_in,
  output logic [NUM_OUT-1:0] sig_out,
  input  logic               cfg_en,
  input  logic               cfg_din,
  output logic               cfg_dout,
  input  logic               cfg_commit,
  output logic               cfg_valid,
  output logic               cfg_err
);

  localparam int SEL_W    = calc_sel_w(NUM_IN);
  localparam int CFG_BITS = calc_cfg_bits(NUM_IN, NUM_OUT);

  logic [CFG_BITS-1:0] w_active_sel;
  logic [NUM_OUT-1:0]  w_mux;

  term_sm_cfg_chain #(
    .NUM_IN  (NUM_IN),
    .NUM_OUT (NUM_OUT),
    .SEL_W   (SEL_W),
    .CFG_BITS(CFG_BITS)
  ) u_chain (
    .i_clk       (UserCLK),
    .i_rst_n     (resetn),
    .i_cfg_en    (cfg_en),
    .i_cfg_din   (cfg_din),
    .i_cfg_commit(cfg_commit),
    .o_cfg_dout  (cfg_dout),
    .o_cfg_valid (cfg_valid),
    .o_cfg_err   (cfg_err),
    .o_active_sel(w_active_sel)
  );

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    logic [SEL_W-1:0] w_sel;
    logic             w_bit;

    assign w_sel = w_active_sel[k*SEL_W +: SEL_W];

    // One-hot decode: a select beyond the last input matches nothing and yields 0.
    always_comb begin
      w_bit = 1'b0;
      for (int j = 0; j < NUM_IN; j++) begin
        w_bit = w_bit | ((w_sel == SEL_W'(j)) & sig_in[j]);
      end
    end

    assign w_mux[k] = w_bit;
  end

`ifdef OUTPUT_REG_EN
  logic [NUM_OUT-1:0] r_sig_out;

  // Output retiming stage.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) r_sig_out <= {NUM_OUT{1'b0}};
    else         r_sig_out <= w_mux;
  end

  assign sig_out = r_sig_out;
`else
  assign sig_out = w_mux;
`endif

endmodule

// File: tb/tb_term_switch_matrix_cfg.sv
// Directed bench for term_switch_matrix_cfg at NUM_IN=8, NUM_OUT=4 (12-bit chain).
module tb_term_switch_matrix_cfg;

  logic       UserCLK = 1'b0;
  logic       resetn;
  logic [7:0] sig_in;
  logic [3:0] sig_out;
  logic       cfg_en;
  logic       cfg_din;
  logic       cfg_dout;
  logic       cfg_commit;
  logic       cfg_valid;
  logic       cfg_err;

  int vectors    = 0;
  int miscompares = 0;
  logic [31:0] dv;

  term_switch_matrix_cfg #(.NUM_IN(8), .NUM_OUT(4)) dut (
    .UserCLK   (UserCLK),
    .resetn    (resetn),
    .sig_in    (sig_in),
    .sig_out   (sig_out),
    .cfg_en    (cfg_en),
    .cfg_din   (cfg_din),
    .cfg_dout  (cfg_dout),
    .cfg_commit(cfg_commit),
    .cfg_valid (cfg_valid),
    .cfg_err   (cfg_err)
  );

  always #5 UserCLK = ~UserCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge UserCLK);
    #1;
  endtask

  // Drive sig_in and let it reach sig_out (one extra edge when outputs are registered).
  task automatic apply_in(input logic [7:0] v);
    sig_in = v;
`ifdef OUTPUT_REG_EN
    tick();
`else
    #1;
`endif
  endtask

  // Shift n bits MSB-first; dout_v collects cfg_dout after each shift, first bit highest.
  task automatic shift_bits(input logic [31:0] bits, input int n, output logic [31:0] dout_v);
    dout_v = 32'd0;
    for (int i = n - 1; i >= 0; i--) begin
      cfg_din = bits[i];
      cfg_en  = 1'b1;
      tick();
      dout_v = {dout_v[30:0], cfg_dout};
    end
    cfg_en  = 1'b0;
    cfg_din = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; sig_in = 8'h00; cfg_en = 1'b0; cfg_din = 1'b0; cfg_commit = 1'b0;
    #2;
    check("rst_dout", {31'd0, cfg_dout}, 32'd0);
    check("rst_valid", {31'd0, cfg_valid}, 32'd0);
    check("rst_err", {31'd0, cfg_err}, 32'd0);
    #10 resetn = 1'b1;

    // Default reversed map: out i <- in 7-i.
    apply_in(8'h01); check("def_in0", {28'd0, sig_out}, 32'h0);
    apply_in(8'h80); check("def_in7", {28'd0, sig_out}, 32'h1);
    apply_in(8'h10); check("def_in4", {28'd0, sig_out}, 32'h8);

    // Identity map {3,2,1,0} = 12'h688.
    shift_bits(32'h688, 12, dv);
    check("load1_dout", dv, 32'h000);
    commit();
    check("c1_valid", {31'd0, cfg_valid}, 32'd1);
    check("c1_err", {31'd0, cfg_err}, 32'd0);
    apply_in(8'h0F); check("id_0F", {28'd0, sig_out}, 32'hF);
    apply_in(8'h05); check("id_05", {28'd0, sig_out}, 32'h5);

`ifdef OUTPUT_REG_EN
    sig_in = 8'h00; tick();
    sig_in = 8'h0F; #1;
    check("oreg_hold", {28'd0, sig_out}, 32'h0);
    tick();
    check("oreg_lat1", {28'd0, sig_out}, 32'hF);
`endif

    // Partial load then commit: error, active unchanged.
    shift_bits(32'h02, 7, dv);
    check("part_dout", dv, 32'h34);
    commit();
    check("part_err", {31'd0, cfg_err}, 32'd1);
    check("part_valid", {31'd0, cfg_valid}, 32'd1);
    apply_in(8'h01); check("part_keep", {28'd0, sig_out}, 32'h1);
    // Finish the load: 7+5 bits form {0,1,2,3} = 12'h053.
    shift_bits(32'h13, 5, dv);
    check("rest_dout", dv, 32'h08);
    commit();
    check("c2_err", {31'd0, cfg_err}, 32'd0);
    apply_in(8'h01); check("rev_in0", {28'd0, sig_out}, 32'h8);
    apply_in(8'h08); check("rev_in3", {28'd0, sig_out}, 32'h1);
    apply_in(8'h06); check("rev_in12", {28'd0, sig_out}, 32'h6);

    // Overflow: 3 extra leading bits 101, then {1,3,5,7} = 12'h2EF.
    shift_bits(32'h52EF, 15, dv);
    check("ovf_dout", dv, 32'h29D);
    commit();
    check("c3_err", {31'd0, cfg_err}, 32'd0);
    apply_in(8'hAA); check("ovf_AA", {28'd0, sig_out}, 32'hF);
    apply_in(8'h80); check("ovf_in7", {28'd0, sig_out}, 32'h1);
    apply_in(8'h02); check("ovf_in1", {28'd0, sig_out}, 32'h8);

    // Simultaneous enable and commit with a full count: commit wins, no shift.
    shift_bits(32'h688, 12, dv);
    check("load4_dout", dv, 32'h2EF);
    cfg_en = 1'b1; cfg_din = 1'b1; cfg_commit = 1'b1;
    tick();
    cfg_en = 1'b0; cfg_din = 1'b0; cfg_commit = 1'b0;
    check("sim_dout", {31'd0, cfg_dout}, 32'd1);
    check("sim_err", {31'd0, cfg_err}, 32'd0);
    apply_in(8'h05); check("sim_05", {28'd0, sig_out}, 32'h5);
    shift_bits(32'h053, 12, dv);
    check("sim_shadow", dv, 32'h688);

    // Reset in the middle of a load.
    shift_bits(32'h3F, 6, dv);
    resetn = 1'b0;
    #1;
    check("mid_valid", {31'd0, cfg_valid}, 32'd0);
    check("mid_err", {31'd0, cfg_err}, 32'd0);
    check("mid_dout", {31'd0, cfg_dout}, 32'd0);
    apply_in(8'h80);
`ifdef OUTPUT_REG_EN
    check("mid_def7", {28'd0, sig_out}, 32'h0);
`else
    check("mid_def7", {28'd0, sig_out}, 32'h1);
`endif
    #2 resetn = 1'b1;
    commit();
    check("post_err", {31'd0, cfg_err}, 32'd1);
    check("post_valid", {31'd0, cfg_valid}, 32'd0);
    apply_in(8'h80); check("post_def7", {28'd0, sig_out}, 32'h1);
    apply_in(8'h10); check("post_def4", {28'd0, sig_out}, 32'h8);
    shift_bits(32'h688, 12, dv);
    check("post_shadow", dv, 32'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
